// File: rtl/bkm_tb_pkg.sv
// Shared types and helpers for the BKM data-step stimulus driver and golden model:
// FSM encoding, digit codes, LFSR polynomial and the digit decoder.
package bkm_tb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } drv_state_e;

  localparam logic [1:0] D_ZERO = 2'b00;
  localparam logic [1:0] D_POS  = 2'b01;
  localparam logic [1:0] D_NEG  = 2'b11;

  // Right-shifting Galois form of x^64+x^63+x^61+x^60+1
  localparam logic [63:0] LFSR_POLY = 64'hD800_0000_0000_0000;

  function automatic logic [1:0] digit_decode(input logic [1:0] code);
    case (code)
      2'b01:   return D_POS;
      2'b11:   return D_NEG;
      default: return D_ZERO;
    endcase
  endfunction

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/bkm_data_step_model.sv
// Combinational BKM E-mode step golden model, modulo 2^W:
// X' = X + dx*(X>>>n) - dy*(Y>>>n), Y' = Y + dx*(Y>>>n) + dy*(X>>>n).
module bkm_data_step_model import bkm_tb_pkg::*; #(
  parameter int W = 64
) (
  input  logic [W-1:0]         X_n,
  input  logic [W-1:0]         Y_n,
  input  logic [1:0]           dx,
  input  logic [1:0]           dy,
  input  logic [$clog2(W)-1:0] n,
  output logic [W-1:0]         X_np1,
  output logic [W-1:0]         Y_np1
);

  logic [W-1:0] sx, sy;

  // Digit product as select/negate/zero; no multiplier
  function automatic logic [W-1:0] dmul(input logic [1:0] d, input logic [W-1:0] v);
    case (d)
      D_POS:   return v;
      D_NEG:   return -v;
      default: return '0;
    endcase
  endfunction

  assign sx = $signed(X_n) >>> n;
  assign sy = $signed(Y_n) >>> n;

  assign X_np1 = X_n + dmul(dx, sx) - dmul(dy, sy);
  assign Y_np1 = Y_n + dmul(dx, sy) + dmul(dy, sx);

endmodule

// File: rtl/bkm_data_step_driver.sv
// LFSR stimulus generator + delayed golden results for the BKM data-step bench.
// Optional stall insertion (LFSR bit 63 in RUN) when BKM_DRV_STALL_EN is defined.
module bkm_data_step_driver import bkm_tb_pkg::*; #(
  parameter int          W     = 64,
  parameter int          LAT   = 1,
  parameter int          N_VEC = 256,
  parameter logic [63:0] SEED  = 64'h1
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [W-1:0]         X_n,
  output logic [W-1:0]         Y_n,
  output logic [1:0]           dx,
  output logic [1:0]           dy,
  output logic [$clog2(W)-1:0] n,
  output logic                 vec_valid,
  output logic [W-1:0]         tb_X_np1,
  output logic [W-1:0]         tb_Y_np1,
  output logic                 chk_enable,
  output logic [31:0]          vec_cnt
);

  localparam int          NW       = $clog2(W);
  localparam logic [63:0] SEED_EFF = (SEED == 64'h0) ? 64'h1 : SEED;

  drv_state_e     state, state_nxt;
  logic [63:0]    lfsr;
  logic [3:0]     drain_cnt;
  logic           last_vec, gen_slot, stall;
  logic [W-1:0]   x_fld, y_rev, x_m, y_m;
  logic [NW-1:0]  n_fld;

  assign last_vec = vec_valid && (vec_cnt == 32'(N_VEC - 1));
  assign gen_slot = ((state == S_IDLE) && start) || ((state == S_RUN) && !last_vec);

`ifdef BKM_DRV_STALL_EN
  assign stall = (state == S_RUN) && lfsr[63];
`else
  assign stall = 1'b0;
`endif

  assign busy = (state == S_RUN) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  assign x_fld = lfsr[W-1:0];
  assign n_fld = NW'(32'(lfsr[5 +: NW]) % 32'(W));

  always_comb begin
    y_rev = '0;
    for (int i = 0; i < W; i++) y_rev[i] = lfsr[W-1-i];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_vec) state_nxt = (LAT == 0) ? S_DONE : S_DRAIN;
      S_DRAIN: if (drain_cnt == 4'(LAT - 1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= S_IDLE;
      lfsr      <= SEED_EFF;
      drain_cnt <= '0;
      vec_cnt   <= '0;
      vec_valid <= 1'b0;
      X_n       <= '0;
      Y_n       <= '0;
      dx        <= D_ZERO;
      dy        <= D_ZERO;
      n         <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 4'd1 : 4'd0;
      if ((state == S_IDLE) && start)      vec_cnt <= '0;
      else if ((state == S_RUN) && vec_valid) vec_cnt <= vec_cnt + 32'd1;
      if (gen_slot) begin
        // A stall slot still consumes an LFSR state; operands hold
        lfsr      <= lfsr_step(lfsr);
        vec_valid <= !stall;
        if (!stall) begin
          X_n <= x_fld;
          Y_n <= y_rev;
          dx  <= digit_decode(lfsr[1:0]);
          dy  <= digit_decode(lfsr[3:2]);
          n   <= n_fld;
        end
      end else begin
        vec_valid <= 1'b0;
        if (!(state_nxt inside {S_RUN, S_DRAIN})) begin
          X_n <= '0;
          Y_n <= '0;
          dx  <= D_ZERO;
          dy  <= D_ZERO;
          n   <= '0;
        end
      end
    end
  end

  bkm_data_step_model #(.W(W)) u_model (
    .X_n   (X_n),
    .Y_n   (Y_n),
    .dx    (dx),
    .dy    (dy),
    .n     (n),
    .X_np1 (x_m),
    .Y_np1 (y_m)
  );

  if (LAT == 0) begin : g_comb
    assign chk_enable = vec_valid;
    assign tb_X_np1   = x_m;
    assign tb_Y_np1   = y_m;
  end else begin : g_pipe
    logic [LAT:1]        vld_pipe;
    logic [LAT:1][W-1:0] x_pipe, y_pipe;

    always_ff @(posedge clk) begin
      if (srst) begin
        vld_pipe <= '0;
        x_pipe   <= '0;
        y_pipe   <= '0;
      end else begin
        vld_pipe[1] <= vec_valid;
        x_pipe[1]   <= x_m;
        y_pipe[1]   <= y_m;
        for (int i = 2; i <= LAT; i++) begin
          vld_pipe[i] <= vld_pipe[i-1];
          x_pipe[i]   <= x_pipe[i-1];
          y_pipe[i]   <= y_pipe[i-1];
        end
      end
    end

    assign chk_enable = vld_pipe[LAT];
    assign tb_X_np1   = x_pipe[LAT];
    assign tb_Y_np1   = y_pipe[LAT];
  end

endmodule

// File: tb/tb_bkm_data_step_driver.sv
// Directed bench for bkm_data_step_driver (W=8) and its golden model sub-module.
module tb_bkm_data_step_driver;
  import bkm_tb_pkg::*;

  logic clk = 1'b0;
  logic srst = 1'b1;
  logic a_start = 1'b0;
  logic b_start = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic       a_busy, a_done, a_vv, a_chk;
  logic [7:0] a_x, a_y, a_tx, a_ty;
  logic [1:0] a_dx, a_dy;
  logic [2:0] a_n;
  logic [31:0] a_cnt;

  logic       b_busy, b_done, b_vv, b_chk;
  logic [7:0] b_x, b_y, b_tx, b_ty;
  logic [1:0] b_dx, b_dy;
  logic [2:0] b_n;
  logic [31:0] b_cnt;

  logic [7:0] m_x, m_y, m_xo, m_yo;
  logic [1:0] m_dx, m_dy;
  logic [2:0] m_n;

  // Hand-derived stream for SEED=0xB6
  logic [7:0] ex_x  [4] = '{8'hB6, 8'h5B, 8'h2D, 8'h16};
  logic [7:0] ex_y  [4] = '{8'h6D, 8'hDA, 8'hB4, 8'h68};
  logic [1:0] ex_dx [4] = '{2'b00, 2'b11, 2'b01, 2'b00};
  logic [1:0] ex_dy [4] = '{2'b01, 2'b00, 2'b11, 2'b01};
  logic [2:0] ex_n  [4] = '{3'd5, 3'd2, 3'd1, 3'd0};
  logic [7:0] ex_tx [4] = '{8'hB3, 8'h45, 8'h1D, 8'hAE};
  logic [7:0] ex_ty [4] = '{8'h6A, 8'hE4, 8'h78, 8'h7E};

  bkm_data_step_driver #(.W(8), .LAT(1), .N_VEC(4), .SEED(64'hB6)) dut (
    .clk(clk), .srst(srst), .start(a_start), .busy(a_busy), .done(a_done),
    .X_n(a_x), .Y_n(a_y), .dx(a_dx), .dy(a_dy), .n(a_n), .vec_valid(a_vv),
    .tb_X_np1(a_tx), .tb_Y_np1(a_ty), .chk_enable(a_chk), .vec_cnt(a_cnt)
  );

  bkm_data_step_driver #(.W(8), .LAT(0), .N_VEC(2), .SEED(64'h0)) dut0 (
    .clk(clk), .srst(srst), .start(b_start), .busy(b_busy), .done(b_done),
    .X_n(b_x), .Y_n(b_y), .dx(b_dx), .dy(b_dy), .n(b_n), .vec_valid(b_vv),
    .tb_X_np1(b_tx), .tb_Y_np1(b_ty), .chk_enable(b_chk), .vec_cnt(b_cnt)
  );

  bkm_data_step_model #(.W(8)) model (
    .X_n(m_x), .Y_n(m_y), .dx(m_dx), .dy(m_dy), .n(m_n), .X_np1(m_xo), .Y_np1(m_yo)
  );

  task automatic test_reset();
    srst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({a_busy, a_done, a_vv, a_chk} !== 4'b0000) begin errors++; $display("FAIL reset_ctl got %b exp 0000", {a_busy, a_done, a_vv, a_chk}); end
    checks++; if ({a_x, a_y, a_tx, a_ty, a_dx, a_dy, a_n} !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", {a_x, a_y, a_tx, a_ty}); end
    checks++; if (a_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", a_cnt); end
    checks++; if ({b_busy, b_done, b_vv, b_chk, b_x, b_tx, b_ty} !== '0) begin errors++; $display("FAIL reset_lat0 got %h exp 0", {b_x, b_tx, b_ty}); end
    srst = 1'b0;
  endtask

  task automatic test_model();
    logic [1:0] code;
    m_x = 8'h40; m_y = 8'h00; m_dx = 2'b01; m_dy = 2'b00; m_n = 3'd1; #1;
    checks++; if ({m_xo, m_yo} !== 16'h6000) begin errors++; $display("FAIL model_pos got %h exp 6000", {m_xo, m_yo}); end
    m_dy = 2'b11; #1;
    checks++; if ({m_xo, m_yo} !== 16'h60E0) begin errors++; $display("FAIL model_negdy got %h exp 60e0", {m_xo, m_yo}); end
    m_x = 8'h7F; m_y = 8'h00; m_dx = 2'b01; m_dy = 2'b00; m_n = 3'd0; #1;
    checks++; if (m_xo !== 8'hFE) begin errors++; $display("FAIL model_wrap got %h exp fe", m_xo); end
    code = 2'b10;
    checks++; if (digit_decode(code) !== 2'b00) begin errors++; $display("FAIL decode_10 got %b exp 00", digit_decode(code)); end
    code = 2'b11;
    checks++; if (digit_decode(code) !== 2'b11) begin errors++; $display("FAIL decode_11 got %b exp 11", digit_decode(code)); end
  endtask

  task automatic test_stream();
    @(negedge clk); a_start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk); a_start = 1'b0;
      checks++; if (a_vv !== (c <= 4)) begin errors++; $display("FAIL stream_vv c=%0d got %b", c, a_vv); end
      if (c <= 4) begin
        checks++;
        if ({a_x, a_y, a_dx, a_dy, a_n} !== {ex_x[c-1], ex_y[c-1], ex_dx[c-1], ex_dy[c-1], ex_n[c-1]}) begin
          errors++; $display("FAIL stream_ops c=%0d got %h exp %h", c, {a_x, a_y, a_dx, a_dy, a_n},
                             {ex_x[c-1], ex_y[c-1], ex_dx[c-1], ex_dy[c-1], ex_n[c-1]});
        end
      end
      checks++; if (a_chk !== (c >= 2 && c <= 5)) begin errors++; $display("FAIL stream_chk c=%0d got %b", c, a_chk); end
      if (c >= 2 && c <= 5) begin
        checks++;
        if ({a_tx, a_ty} !== {ex_tx[c-2], ex_ty[c-2]}) begin
          errors++; $display("FAIL stream_res c=%0d got %h exp %h", c, {a_tx, a_ty}, {ex_tx[c-2], ex_ty[c-2]});
        end
      end
      checks++; if ({a_busy, a_done} !== {c <= 5, c == 6}) begin errors++; $display("FAIL stream_bd c=%0d got %b", c, {a_busy, a_done}); end
    end
    checks++; if (a_cnt !== 32'd4) begin errors++; $display("FAIL stream_cnt got %0d exp 4", a_cnt); end
    checks++; if ({a_x, a_y} !== 16'h0000) begin errors++; $display("FAIL stream_idle_ops got %h exp 0", {a_x, a_y}); end
  endtask

  task automatic test_abort();
    bit seen;
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({a_vv, a_busy} !== 2'b11) begin errors++; $display("FAIL abort_midrun got %b exp 11", {a_vv, a_busy}); end
    srst = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_busy, a_done, a_vv, a_chk, a_x, a_y, a_dx, a_dy, a_n, a_tx, a_ty, a_cnt} !== '0) begin
      errors++; $display("FAIL abort_zero got %h exp 0", {a_busy, a_done, a_vv, a_chk, a_x, a_y, a_tx, a_ty, a_cnt});
    end
    srst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++; if ({a_done, a_busy} !== 2'b00) begin errors++; $display("FAIL abort_nodone got %b exp 00", {a_done, a_busy}); end
    end
    a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    checks++;
    if ({a_vv, a_x, a_y, a_dx, a_dy, a_n} !== {1'b1, ex_x[0], ex_y[0], ex_dx[0], ex_dy[0], ex_n[0]}) begin
      errors++; $display("FAIL abort_replay got %h exp %h", {a_vv, a_x, a_y, a_dx, a_dy, a_n},
                         {1'b1, ex_x[0], ex_y[0], ex_dx[0], ex_dy[0], ex_n[0]});
    end
    @(negedge clk);
    checks++; if ({a_chk, a_tx, a_ty} !== {1'b1, ex_tx[0], ex_ty[0]}) begin errors++; $display("FAIL abort_replay_res got %h exp %h", {a_chk, a_tx, a_ty}, {1'b1, ex_tx[0], ex_ty[0]}); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_done) begin seen = 1'b1; break; end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL abort_rerun_done got %b exp 1", seen); end
    @(negedge clk);
  endtask

  task automatic test_start_held();
    int ndone;
    @(negedge clk); b_start = 1'b1;
    @(negedge clk);
    checks++; if ({b_vv, b_busy, b_x, b_y, b_dx, b_dy, b_n} !== {2'b11, 8'h01, 8'h80, 2'b01, 2'b00, 3'd0}) begin
      errors++; $display("FAIL held_v0 got %h", {b_vv, b_busy, b_x, b_y, b_dx, b_dy, b_n}); end
    checks++; if ({b_chk, b_tx, b_ty} !== {1'b1, 8'h02, 8'h00}) begin errors++; $display("FAIL held_r0 got %h exp 10200", {b_chk, b_tx, b_ty}); end
    @(negedge clk);
    checks++; if ({b_vv, b_chk, b_busy, b_x, b_tx, b_ty} !== {3'b111, 8'h00, 8'h00, 8'h00}) begin
      errors++; $display("FAIL held_v1 got %h", {b_vv, b_chk, b_busy, b_x, b_tx, b_ty}); end
    @(negedge clk);
    checks++; if ({b_done, b_busy, b_cnt} !== {2'b10, 32'd2}) begin errors++; $display("FAIL held_done got %h", {b_done, b_busy, b_cnt}); end
    @(negedge clk);
    checks++; if ({b_done, b_busy, b_vv, b_cnt} !== {3'b000, 32'd2}) begin errors++; $display("FAIL held_idle got %h", {b_done, b_busy, b_vv, b_cnt}); end
    @(negedge clk); b_start = 1'b0;
    checks++; if ({b_busy, b_vv} !== 2'b11) begin errors++; $display("FAIL held_rerun got %b exp 11", {b_busy, b_vv}); end
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b_done) ndone++;
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL held_rerun_done got %0d exp 1", ndone); end
  endtask

  task automatic test_count();
    bit seen;
    int nv, nc;
    seen = 1'b0; nv = 0; nc = 0;
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (a_done) begin seen = 1'b1; break; end
      if (a_vv) nv++;
      if (a_chk) nc++;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL count_timeout got %b exp 1", seen); end
    checks++; if (nv !== 4) begin errors++; $display("FAIL count_vv got %0d exp 4", nv); end
    checks++; if (nc !== 4) begin errors++; $display("FAIL count_chk got %0d exp 4", nc); end
    checks++; if (a_cnt !== 32'd4) begin errors++; $display("FAIL count_cnt got %0d exp 4", a_cnt); end
  endtask

  initial begin
    test_reset();
    test_model();
`ifndef BKM_DRV_STALL_EN
    test_stream();
    test_abort();
    test_start_held();
`endif
    test_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
